alu_op_sel_encoder: RTL and testbench

Converts a 4-bit ALU operation code into the 6-bit select pattern consumed by `fpga_sel_decoder`, the board-side ALU operation decoder. It accepts one opcode per valid/ready handshake and drives the pattern for a programmable number of cycles. It then inserts one idle cycle so that two identical back-to-back codes are still seen as separate events. Illegal opcodes are rejected, flagged and counted. The block sits between the control sequencer and the select-decode path.

---
 rtl/alu_op_sel_encoder_if.sv | 12 +
 rtl/alu_op_sel_encoder.sv | 68 ++++++
 tb/tb_alu_op_sel_encoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_op_sel_encoder_if.sv
// alu_op_sel_encoder_if: opcode handshake and select-pattern bundle
interface alu_op_sel_encoder_if;
    logic       op_valid;
    logic [3:0] op;
    logic       op_ready;
    logic [5:0] sel;
    logic       sel_valid;
    logic       err;
    logic [7:0] err_count;
    modport master (output op_valid, op, input op_ready, sel, sel_valid, err, err_count);
    modport slave (input op_valid, op, output op_ready, sel, sel_valid, err, err_count);
endinterface

// File: rtl/alu_op_sel_encoder.sv
// alu_op_sel_encoder: opcode to one-cold select pattern, held then followed by an idle gap
module alu_op_sel_encoder #(
    parameter int HOLD_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    alu_op_sel_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
    localparam logic [5:0] IDLE_PAT = 6'b011111;
    localparam logic [7:0] LOAD = 8'(HOLD_CYCLES - 1);
    state_t     r_state, w_next;
    logic [5:0] r_sel, w_sel;
    logic       r_sel_valid, w_sel_valid;
    logic       r_err, w_err;
    logic [7:0] r_err_count, w_err_count;
    logic [7:0] r_cnt, w_cnt;
    logic       w_legal, w_xfer;
    logic [5:0] w_enc;
    assign w_legal = bus.op[2:0] <= 3'd4;
    assign w_xfer = bus.op_valid && (r_state == IDLE);
    assign w_enc = {bus.op[3], ~(5'b10000 >> bus.op[2:0])};
    // next state, pattern, counter and error bookkeeping
    always_comb begin
        w_next = r_state;
        w_sel = r_sel;
        w_sel_valid = r_sel_valid;
        w_cnt = r_cnt;
        w_err = w_xfer && !w_legal;
        w_err_count = (w_err && r_err_count != 8'hff) ? r_err_count + 8'd1 : r_err_count;
        if (r_state == IDLE && w_xfer && w_legal) begin
            w_next = HOLD;
            w_sel = w_enc;
            w_sel_valid = 1'b1;
            w_cnt = LOAD;
        end else if (r_state == HOLD) begin
            w_next = (r_cnt == 8'd0) ? GAP : HOLD;
            w_cnt = (r_cnt == 8'd0) ? r_cnt : r_cnt - 8'd1;
            w_sel = (r_cnt == 8'd0) ? IDLE_PAT : r_sel;
            w_sel_valid = r_cnt != 8'd0;
        end else if (r_state == GAP) begin
            w_next = IDLE;
        end
    end
    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel <= IDLE_PAT;
            r_sel_valid <= 1'b0;
            r_err <= 1'b0;
            r_err_count <= 8'd0;
            r_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            r_sel <= w_sel;
            r_sel_valid <= w_sel_valid;
            r_err <= w_err;
            r_err_count <= w_err_count;
            r_cnt <= w_cnt;
        end
    end
    assign bus.op_ready = r_state == IDLE;
    assign bus.sel = r_sel;
    assign bus.sel_valid = r_sel_valid;
    assign bus.err = r_err;
    assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_alu_op_sel_encoder.sv
// tb_alu_op_sel_encoder: directed vector bench for the opcode select encoder
module tb_alu_op_sel_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    alu_op_sel_encoder_if if4();
    alu_op_sel_encoder_if if1();
    alu_op_sel_encoder #(.HOLD_CYCLES(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    alu_op_sel_encoder #(.HOLD_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    int passed = 0;
    int total = 0;
    typedef struct {logic [3:0] op; logic [5:0] sel;} vec_t;
    vec_t vecs[10];
    localparam logic [5:0] IP = 6'b011111;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!if4.op_ready && n < 20) begin
            tick;
            n++;
        end
        chk("ready_wait", {7'd0, if4.op_ready}, 8'd1);
    endtask

    // expects a 4-cycle hold of s, the gap cycle, then ready again
    task automatic hold_seq(input logic [5:0] s);
        for (int k = 0; k < 4; k++) begin
            chk("hold_sel", {2'b0, if4.sel}, {2'b0, s});
            chk("hold_valid", {7'd0, if4.sel_valid}, 8'd1);
            chk("hold_ready", {7'd0, if4.op_ready}, 8'd0);
            tick;
        end
        chk("gap_sel", {2'b0, if4.sel}, {2'b0, IP});
        chk("gap_valid", {7'd0, if4.sel_valid}, 8'd0);
        chk("gap_ready", {7'd0, if4.op_ready}, 8'd0);
        tick;
        chk("ready_back", {7'd0, if4.op_ready}, 8'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        vecs = '{'{4'd0, 6'b001111}, '{4'd1, 6'b010111}, '{4'd2, 6'b011011},
                 '{4'd3, 6'b011101}, '{4'd4, 6'b011110}, '{4'd8, 6'b101111},
                 '{4'd9, 6'b110111}, '{4'd10, 6'b111011}, '{4'd11, 6'b111101},
                 '{4'd12, 6'b111110}};
        if4.op_valid = 1'b0;
        if4.op = 4'd0;
        if1.op_valid = 1'b0;
        if1.op = 4'd0;
        #12;
        chk("rst_sel", {2'b0, if4.sel}, {2'b0, IP});
        chk("rst_valid", {7'd0, if4.sel_valid}, 8'd0);
        chk("rst_err", {7'd0, if4.err}, 8'd0);
        chk("rst_cnt", if4.err_count, 8'd0);
        #1 rst = 1'b0;
        tick;
        chk("rst_ready", {7'd0, if4.op_ready}, 8'd1);
        for (int i = 0; i < 10; i++) begin
            wait_ready;
            if4.op = vecs[i].op;
            if4.op_valid = 1'b1;
            tick;
            if4.op_valid = 1'b0;
            hold_seq(vecs[i].sel);
        end
        if4.op = 4'd3;
        if4.op_valid = 1'b1;
        tick;
        hold_seq(6'b011101);
        tick;
        if4.op_valid = 1'b0;
        hold_seq(6'b011101);
        if4.op_valid = 1'b1;
        if4.op = 4'd5;
        tick;
        chk("ill5_err", {7'd0, if4.err}, 8'd1);
        chk("ill5_cnt", if4.err_count, 8'd1);
        if4.op = 4'd7;
        tick;
        chk("ill7_err", {7'd0, if4.err}, 8'd1);
        chk("ill7_cnt", if4.err_count, 8'd2);
        if4.op = 4'd15;
        tick;
        chk("ill15_err", {7'd0, if4.err}, 8'd1);
        chk("ill15_cnt", if4.err_count, 8'd3);
        chk("ill_sel", {2'b0, if4.sel}, {2'b0, IP});
        chk("ill_valid", {7'd0, if4.sel_valid}, 8'd0);
        chk("ill_ready", {7'd0, if4.op_ready}, 8'd1);
        if4.op_valid = 1'b0;
        tick;
        chk("ill_err_drop", {7'd0, if4.err}, 8'd0);
        chk("ill_cnt_hold", if4.err_count, 8'd3);
        if4.op_valid = 1'b1;
        if4.op = 4'd13;
        for (int i = 0; i < 300; i++) tick;
        if4.op_valid = 1'b0;
        tick;
        chk("sat_cnt", if4.err_count, 8'd255);
        if4.op = 4'd0;
        if4.op_valid = 1'b1;
        tick;
        if4.op = 4'd9;
        hold_seq(6'b001111);
        tick;
        if4.op_valid = 1'b0;
        hold_seq(6'b110111);
        if4.op = 4'd12;
        if4.op_valid = 1'b1;
        tick;
        if4.op_valid = 1'b0;
        chk("mid_sel", {2'b0, if4.sel}, 8'b00111110);
        tick;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sel", {2'b0, if4.sel}, {2'b0, IP});
        chk("mid_rst_valid", {7'd0, if4.sel_valid}, 8'd0);
        chk("mid_rst_cnt", if4.err_count, 8'd0);
        chk("mid_rst_ready", {7'd0, if4.op_ready}, 8'd1);
        #1 rst = 1'b0;
        tick;
        chk("post_rst_ready", {7'd0, if4.op_ready}, 8'd1);
        chk("post_rst_sel", {2'b0, if4.sel}, {2'b0, IP});
        if1.op = 4'd2;
        if1.op_valid = 1'b1;
        tick;
        if1.op_valid = 1'b0;
        chk("h1_sel", {2'b0, if1.sel}, 8'b00011011);
        chk("h1_valid", {7'd0, if1.sel_valid}, 8'd1);
        chk("h1_ready", {7'd0, if1.op_ready}, 8'd0);
        tick;
        chk("h1_gap_sel", {2'b0, if1.sel}, {2'b0, IP});
        chk("h1_gap_valid", {7'd0, if1.sel_valid}, 8'd0);
        chk("h1_gap_ready", {7'd0, if1.op_ready}, 8'd0);
        tick;
        chk("h1_ready_back", {7'd0, if1.op_ready}, 8'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
